// File: rtl/issue_pick_mux_data_rr.sv
// Issue pick mux: round-robin selection of one eligible issue-queue entry,
// latched into a registered output stage with valid/ready handshake.
module issue_pick_mux_data_rr #(
    parameter int ENTRIES = 4,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 4,
    parameter int BP_W    = 2,
    localparam int PICK_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        snoop_hit,
    input  logic                        bco_valid,
    input  logic [ENTRIES-1:0]          i_valid,
    input  logic [ENTRIES*ROB_W-1:0]    i_src0_rob,
    input  logic [ENTRIES*ROB_W-1:0]    i_src1_rob,
    input  logic [ENTRIES-1:0]          i_src0_rdy,
    input  logic [ENTRIES-1:0]          i_src1_rdy,
    input  logic [ENTRIES*DATA_W-1:0]   i_src0_value,
    input  logic [ENTRIES*DATA_W-1:0]   i_src1_value,
    input  logic [ENTRIES*ROB_W-1:0]    i_dst_rob,
    input  logic [ENTRIES-1:0]          i_load,
    input  logic [ENTRIES-1:0]          i_pipe_alu,
    input  logic [ENTRIES*BP_W-1:0]     i_bp_pattern,
    input  logic [ENTRIES-1:0]          i_bp_taken,
    input  logic [ENTRIES-1:0]          i_bp_hit,
    input  logic [ENTRIES*DATA_W-1:0]   i_bp_target,
    input  logic                        i_ready,
    output logic [ENTRIES-1:0]          o_en,
    output logic [PICK_W-1:0]           o_pick,
    output logic                        o_valid,
    output logic [ROB_W-1:0]            o_dst_rob,
    output logic                        o_load,
    output logic                        o_pipe_alu,
    output logic [BP_W-1:0]             o_bp_pattern,
    output logic                        o_bp_taken,
    output logic                        o_bp_hit,
    output logic [DATA_W-1:0]           o_bp_target,
    output logic [DATA_W-1:0]           o_src0_value,
    output logic [DATA_W-1:0]           o_src1_value,
    output logic                        o_src0_forward_alu,
    output logic                        o_src1_forward_alu
);

    logic [ROB_W-1:0]  src0_rob   [ENTRIES];
    logic [ROB_W-1:0]  src1_rob   [ENTRIES];
    logic [ROB_W-1:0]  dst_rob    [ENTRIES];
    logic [DATA_W-1:0] src0_value [ENTRIES];
    logic [DATA_W-1:0] src1_value [ENTRIES];
    logic [DATA_W-1:0] bp_target  [ENTRIES];
    logic [BP_W-1:0]   bp_pattern [ENTRIES];

    for (genvar g = 0; g < ENTRIES; g++) begin : g_unpack
        assign src0_rob[g]   = i_src0_rob[g*ROB_W +: ROB_W];
        assign src1_rob[g]   = i_src1_rob[g*ROB_W +: ROB_W];
        assign dst_rob[g]    = i_dst_rob[g*ROB_W +: ROB_W];
        assign src0_value[g] = i_src0_value[g*DATA_W +: DATA_W];
        assign src1_value[g] = i_src1_value[g*DATA_W +: DATA_W];
        assign bp_target[g]  = i_bp_target[g*DATA_W +: DATA_W];
        assign bp_pattern[g] = i_bp_pattern[g*BP_W +: BP_W];
    end

    logic                 valid_q, valid_d;
    logic [PICK_W-1:0]    pick_q, pick_d;
    logic [PICK_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ROB_W-1:0]     dst_rob_q, dst_rob_d;
    logic                 load_q, load_d;
    logic                 pipe_alu_q, pipe_alu_d;
    logic [BP_W-1:0]      bp_pattern_q, bp_pattern_d;
    logic                 bp_taken_q, bp_taken_d;
    logic                 bp_hit_q, bp_hit_d;
    logic [DATA_W-1:0]    bp_target_q, bp_target_d;
    logic [DATA_W-1:0]    src0_value_q, src0_value_d;
    logic [DATA_W-1:0]    src1_value_q, src1_value_d;
    logic                 fwd0_q, fwd0_d;
    logic                 fwd1_q, fwd1_d;

    logic                 consume;
    logic                 load_en;
    logic [ENTRIES-1:0]   alu_fwd0;
    logic [ENTRIES-1:0]   alu_fwd1;
    logic [ENTRIES-1:0]   eligible;
    logic                 pick_found;
    logic [PICK_W-1:0]    pick_idx;
    logic [PICK_W-1:0]    scan_idx;
    logic                 do_load;

    // A source can be satisfied by the ALU bypass only when the held ALU op retires this cycle.
    always_comb begin
        consume  = valid_q & i_ready;
        load_en  = (~valid_q | i_ready) & ~bco_valid & ~snoop_hit;
        alu_fwd0 = '0;
        alu_fwd1 = '0;
        eligible = '0;
        for (int k = 0; k < ENTRIES; k++) begin
            alu_fwd0[k] = consume & pipe_alu_q & (src0_rob[k] == dst_rob_q);
            alu_fwd1[k] = consume & pipe_alu_q & (src1_rob[k] == dst_rob_q);
            eligible[k] = i_valid[k] & (i_src0_rdy[k] | alu_fwd0[k])
                                     & (i_src1_rdy[k] | alu_fwd1[k]);
        end
    end

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            scan_idx = rr_ptr_q + PICK_W'(i);
            if (!pick_found && eligible[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    assign do_load = pick_found & load_en & ~reset;

    always_comb begin
        o_en = '0;
        if (do_load) begin
            o_en[pick_idx] = 1'b1;
        end
    end

    // Flush and snoop cancel only touch o_valid; payload fields keep their last values.
    always_comb begin
        valid_d      = valid_q;
        pick_d       = pick_q;
        rr_ptr_d     = rr_ptr_q;
        dst_rob_d    = dst_rob_q;
        load_d       = load_q;
        pipe_alu_d   = pipe_alu_q;
        bp_pattern_d = bp_pattern_q;
        bp_taken_d   = bp_taken_q;
        bp_hit_d     = bp_hit_q;
        bp_target_d  = bp_target_q;
        src0_value_d = src0_value_q;
        src1_value_d = src1_value_q;
        fwd0_d       = fwd0_q;
        fwd1_d       = fwd1_q;
        if (do_load) begin
            valid_d      = 1'b1;
            pick_d       = pick_idx;
            rr_ptr_d     = pick_idx + PICK_W'(1);
            dst_rob_d    = dst_rob[pick_idx];
            load_d       = i_load[pick_idx];
            pipe_alu_d   = i_pipe_alu[pick_idx];
            bp_pattern_d = bp_pattern[pick_idx];
            bp_taken_d   = i_bp_taken[pick_idx];
            bp_hit_d     = i_bp_hit[pick_idx];
            bp_target_d  = bp_target[pick_idx];
            src0_value_d = src0_value[pick_idx];
            src1_value_d = src1_value[pick_idx];
            fwd0_d       = alu_fwd0[pick_idx] & ~i_src0_rdy[pick_idx];
            fwd1_d       = alu_fwd1[pick_idx] & ~i_src1_rdy[pick_idx];
        end else if (bco_valid) begin
            valid_d = 1'b0;
        end else if (snoop_hit && valid_q && load_q && !i_ready) begin
            valid_d = 1'b0;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            pick_q       <= '0;
            rr_ptr_q     <= '0;
            dst_rob_q    <= '0;
            load_q       <= 1'b0;
            pipe_alu_q   <= 1'b0;
            bp_pattern_q <= '0;
            bp_taken_q   <= 1'b0;
            bp_hit_q     <= 1'b0;
            bp_target_q  <= '0;
            src0_value_q <= '0;
            src1_value_q <= '0;
            fwd0_q       <= 1'b0;
            fwd1_q       <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            pick_q       <= pick_d;
            rr_ptr_q     <= rr_ptr_d;
            dst_rob_q    <= dst_rob_d;
            load_q       <= load_d;
            pipe_alu_q   <= pipe_alu_d;
            bp_pattern_q <= bp_pattern_d;
            bp_taken_q   <= bp_taken_d;
            bp_hit_q     <= bp_hit_d;
            bp_target_q  <= bp_target_d;
            src0_value_q <= src0_value_d;
            src1_value_q <= src1_value_d;
            fwd0_q       <= fwd0_d;
            fwd1_q       <= fwd1_d;
        end
    end

    assign o_valid            = valid_q;
    assign o_pick             = pick_q;
    assign o_dst_rob          = dst_rob_q;
    assign o_load             = load_q;
    assign o_pipe_alu         = pipe_alu_q;
    assign o_bp_pattern       = bp_pattern_q;
    assign o_bp_taken         = bp_taken_q;
    assign o_bp_hit           = bp_hit_q;
    assign o_bp_target        = bp_target_q;
    assign o_src0_value       = src0_value_q;
    assign o_src1_value       = src1_value_q;
    assign o_src0_forward_alu = fwd0_q;
    assign o_src1_forward_alu = fwd1_q;

endmodule
